proj_index_gen: RTL and testbench
=================================

PROJ_INDEX_GEN -- requirements
Module: proj_index_gen

Interface
REQ-001 SHALL have parameter IDX_W, default 8, giving the index width in bits.
REQ-002 SHALL have parameter LEN_W, default IDX_W+1, giving the sequence-length width in bits; this allows a full 2^IDX_W pass.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle request to begin a sequence.
REQ-006 SHALL have port cfg_base, input, IDX_W bits: the first index of the sequence.
REQ-007 SHALL have port cfg_stride, input, IDX_W bits: the increment between indices.
REQ-008 SHALL have port cfg_len, input, LEN_W bits: the number of indices per pass.
REQ-009 SHALL have port cfg_mode, input, 1 bit: 0 = ONESHOT, 1 = CONTINUOUS.
REQ-010 SHALL have port abort, input, 1 bit: terminates any activity.
REQ-011 SHALL have port idx_ready, input, 1 bit: consumer ready.
REQ-012 SHALL have port idx_valid, output, 1 bit: index is valid.
REQ-013 SHALL have port index, output, IDX_W bits: the current index.
REQ-014 SHALL have port idx_last, output, 1 bit: the current index is the final one of its pass.
REQ-015 SHALL have port busy, output, 1 bit: high in RUN.
REQ-016 SHALL have port finished_count, output, 1 bit: one-cycle pulse at the end of each completed pass.

Function
REQ-017 SHALL implement the states IDLE, RUN and DONE.
REQ-018 SHALL, in IDLE, accept start only when cfg_len != 0: latch base, stride, len and mode, then enter RUN on the next cycle with index = base, idx_valid = 1 and pass count = 0.
REQ-019 SHALL ignore start when cfg_len == 0, staying in IDLE with no outputs changing.
REQ-020 SHALL ignore start in RUN and DONE; the latched configuration is unaffected by cfg_* changes while the block is active.
REQ-021 SHALL define a transfer as idx_valid & idx_ready; on each transfer, index <= index + stride modulo 2^IDX_W (silent wrap) and count <= count + 1.
REQ-022 SHALL hold index, idx_valid and idx_last stable while idx_valid is high and idx_ready is low.
REQ-023 SHALL drive idx_last combinationally from state: high exactly when in RUN and count == len-1.
REQ-024 SHALL, in ONESHOT on a transfer with idx_last high: go to DONE, drop idx_valid, and pulse finished_count for exactly the DONE cycle; DONE then returns to IDLE.
REQ-025 SHALL, in CONTINUOUS on a transfer with idx_last high: pulse finished_count for one cycle, reload index = base and count = 0, and keep idx_valid high with no bubble.
REQ-026 SHALL make abort high in any state force IDLE on the next edge with idx_valid = 0 and no finished_count pulse; abort has priority over a simultaneous transfer or start.
REQ-027 SHALL complete a single-index pass (len = 1) correctly, with idx_last high on the first index.
REQ-028 SHALL support stride = 0, which repeats base for len transfers.
REQ-029 SHALL produce a first-index latency of 1 cycle from the start edge to idx_valid, and a throughput of 1 index per cycle while idx_ready is high.

Reset
REQ-030 SHALL, when rst_n = 0 at a rising clk edge, set the state to IDLE and set index = 0, count = 0, idx_valid = 0, idx_last = 0, busy = 0 and finished_count = 0.
REQ-031 SHALL give reset priority over abort and start.
REQ-032 SHALL, on reset mid-RUN, discard the pass with no finished_count pulse; a new start is accepted on the first cycle after rst_n returns high.

Structure
REQ-033 SHALL place the state enum (IDLE/RUN/DONE) and the mode encoding constants in proj_pkg.
REQ-034 SHALL keep the parameter defaults local to the module.
REQ-035 SHALL have one natural sub-module, proj_stride_acc: a registered modulo-2^IDX_W accumulator with load/enable; the FSM and count stay in proj_index_gen.

Verification
REQ-036 SHALL cover: ONESHOT, base=3, stride=2, len=4, ready always high -> index 3,5,7,9 on consecutive cycles, idx_last on 9, finished_count one cycle later, then IDLE.
REQ-037 SHALL cover: IDX_W=4, base=14, stride=1, len=4 -> index 14,15,0,1 (wrap), with finished_count pulsed once.
REQ-038 SHALL cover: idx_ready low for 3 cycles on the 2nd index -> index is held, no skip, and the total transfer count equals len.
REQ-039 SHALL cover: CONTINUOUS, base=0, stride=1, len=3 -> 0,1,2,0,1,2 with no bubble and a finished_count pulse after each 2; abort then drops idx_valid next cycle.
REQ-040 SHALL cover: abort and transfer in the same cycle mid-pass -> IDLE with no finished_count; start with cfg_len=0 -> busy stays 0.
REQ-041 SHALL cover: rst_n low for 1 cycle mid-RUN -> all outputs 0 on the next edge; a restart with len=2 yields 2 indices and a finished_count pulse.

Source files
------------

// File: rtl/proj_pkg.sv
// Shared types for the projection index generator: FSM state encoding and
// the mode constants used to interpret cfg_mode.
package proj_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT    = 1'b0;
    localparam logic MODE_CONTINUOUS = 1'b1;

endpackage

// File: rtl/proj_stride_acc.sv
// Registered modulo-2^IDX_W accumulator. load has priority over en; the add
// wraps silently at the register width.
module proj_stride_acc #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [IDX_W-1:0] load_val,
    input  logic             en,
    input  logic [IDX_W-1:0] stride,
    output logic [IDX_W-1:0] acc
);

    // Accumulator register: reload, step by stride, or hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (load) begin
            acc <= load_val;
        end else if (en) begin
            acc <= acc + stride;
        end
    end

endmodule

// File: rtl/proj_index_gen.sv
// Strided index sequence generator with valid/ready output handshake.
// One pass emits cfg_len indices base, base+stride, ... (mod 2^IDX_W).
// ONESHOT ends the pass through a DONE cycle; CONTINUOUS restarts at base
// without a bubble. finished_count is a registered pulse one cycle after the
// final transfer of a pass, which in ONESHOT lands exactly on the DONE cycle.
module proj_index_gen
    import proj_pkg::*;
#(
    parameter int IDX_W = 8,
    parameter int LEN_W = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IDX_W-1:0] cfg_base,
    input  logic [IDX_W-1:0] cfg_stride,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_mode,
    input  logic             abort,
    input  logic             idx_ready,
    output logic             idx_valid,
    output logic [IDX_W-1:0] index,
    output logic             idx_last,
    output logic             busy,
    output logic             finished_count
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   base_q, stride_q;
    logic [LEN_W-1:0]   len_q, count_q;
    logic               mode_q;

    logic               xfer, last_xfer;
    logic               cfg_latch;
    logic               acc_load, acc_en;
    logic [IDX_W-1:0]   acc_load_val;

    // Outputs derive from state so they stay stable across ready stalls.
    assign idx_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign idx_last  = (state_q == RUN) && (count_q == len_q - LEN_W'(1));
    assign xfer      = idx_valid & idx_ready;
    assign last_xfer = xfer & idx_last;

    // Next-state and accumulator control; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        cfg_latch    = 1'b0;
        acc_load     = 1'b0;
        acc_en       = 1'b0;
        acc_load_val = base_q;
        case (state_q)
            IDLE: begin
                if (start && (cfg_len != '0)) begin
                    state_d      = RUN;
                    cfg_latch    = 1'b1;
                    acc_load     = 1'b1;
                    acc_load_val = cfg_base;
                end
            end
            RUN: begin
                if (xfer) begin
                    if (idx_last) begin
                        if (mode_q == MODE_ONESHOT) begin
                            state_d = DONE;
                        end else begin
                            acc_load = 1'b1;
                        end
                    end else begin
                        acc_en = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d   = IDLE;
            cfg_latch = 1'b0;
            acc_load  = 1'b0;
            acc_en    = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Configuration capture on an accepted start; frozen while active.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q   <= '0;
            stride_q <= '0;
            len_q    <= '0;
            mode_q   <= MODE_ONESHOT;
        end else if (cfg_latch) begin
            base_q   <= cfg_base;
            stride_q <= cfg_stride;
            len_q    <= cfg_len;
            mode_q   <= cfg_mode;
        end
    end

    // Position within the current pass; wraps to 0 after the final index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (abort || cfg_latch) begin
            count_q <= '0;
        end else if (xfer) begin
            count_q <= idx_last ? '0 : count_q + LEN_W'(1);
        end
    end

    // End-of-pass pulse, suppressed when the pass is aborted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            finished_count <= 1'b0;
        end else begin
            finished_count <= last_xfer & ~abort;
        end
    end

    proj_stride_acc #(
        .IDX_W (IDX_W)
    ) u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (acc_load),
        .load_val (acc_load_val),
        .en       (acc_en),
        .stride   (stride_q),
        .acc      (index)
    );

endmodule

// File: tb/tb_proj_index_gen.sv
// Bench for proj_index_gen: directed vector table, hand-written corner
// sequences, and a randomized run against a pass-position reference model.
module tb_proj_index_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort, idx_ready, cfg_mode;
    logic [7:0] cfg_base, cfg_stride;
    logic [8:0] cfg_len;
    logic       idx_valid, idx_last, busy, finished_count;
    logic [7:0] index;

    logic       start4;
    logic [3:0] cfg_base4, cfg_stride4;
    logic [4:0] cfg_len4;
    logic       idx_valid4, idx_last4, busy4, fin4;
    logic [3:0] index4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    proj_index_gen #(.IDX_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_base(cfg_base),
        .cfg_stride(cfg_stride), .cfg_len(cfg_len), .cfg_mode(cfg_mode),
        .abort(abort), .idx_ready(idx_ready), .idx_valid(idx_valid),
        .index(index), .idx_last(idx_last), .busy(busy),
        .finished_count(finished_count)
    );

    proj_index_gen #(.IDX_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .cfg_base(cfg_base4),
        .cfg_stride(cfg_stride4), .cfg_len(cfg_len4), .cfg_mode(cfg_mode),
        .abort(abort), .idx_ready(idx_ready), .idx_valid(idx_valid4),
        .index(index4), .idx_last(idx_last4), .busy(busy4),
        .finished_count(fin4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] base;
        logic [7:0] stride;
        logic [8:0] len;
        logic [7:0] exp_idx [4];
    } vec_t;

    vec_t vecs [5];

    // Reference model: transaction-level view of a pass.
    bit       m_active, m_cool, m_fin;
    int       m_k;
    int       m_base, m_stride, m_len;
    bit       m_mode;

    task automatic model_step(input bit r_n, input bit st, input bit ab, input bit rdy,
                              input int b, input int s, input int l, input bit md);
        bit last_now;
        last_now = m_active && (m_k == m_len - 1);
        if (!r_n || ab) begin
            m_active = 0; m_cool = 0; m_fin = 0; m_k = 0;
        end else if (m_active) begin
            m_fin = 0;
            if (rdy) begin
                if (last_now) begin
                    m_fin = 1;
                    m_k = 0;
                    if (!md_latched()) begin
                        m_active = 0; m_cool = 1;
                    end
                end else begin
                    m_k++;
                end
            end
        end else if (m_cool) begin
            m_cool = 0; m_fin = 0;
        end else begin
            m_fin = 0;
            if (st && l != 0) begin
                m_active = 1; m_k = 0;
                m_base = b; m_stride = s; m_len = l; m_mode = md;
            end
        end
    endtask

    function automatic bit md_latched();
        return m_mode;
    endfunction

    initial begin
        int xfers, pulses, cyc;
        vecs[0] = '{base:8'd3,   stride:8'd2,   len:9'd4, exp_idx:'{8'd3, 8'd5, 8'd7, 8'd9}};
        vecs[1] = '{base:8'd10,  stride:8'd0,   len:9'd3, exp_idx:'{8'd10, 8'd10, 8'd10, 8'd0}};
        vecs[2] = '{base:8'd200, stride:8'd100, len:9'd3, exp_idx:'{8'd200, 8'd44, 8'd144, 8'd0}};
        vecs[3] = '{base:8'd7,   stride:8'd5,   len:9'd1, exp_idx:'{8'd7, 8'd0, 8'd0, 8'd0}};
        vecs[4] = '{base:8'd255, stride:8'd1,   len:9'd2, exp_idx:'{8'd255, 8'd0, 8'd0, 8'd0}};

        rst_n = 0; start = 0; abort = 0; idx_ready = 1; cfg_mode = 0;
        cfg_base = 0; cfg_stride = 0; cfg_len = 0;
        start4 = 0; cfg_base4 = 0; cfg_stride4 = 0; cfg_len4 = 0;
        tick(); tick();
        chk("reset_valid", idx_valid, 0);
        chk("reset_index", index, 0);
        chk("reset_last", idx_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fin", finished_count, 0);
        rst_n = 1;
        tick();

        // Table: ONESHOT passes with ready held high.
        foreach (vecs[v]) begin
            cfg_base = vecs[v].base; cfg_stride = vecs[v].stride;
            cfg_len = vecs[v].len; cfg_mode = 0; start = 1;
            tick();
            start = 0; cfg_base = 8'hAA; cfg_len = 9'd7;
            for (int k = 0; k < int'(vecs[v].len); k++) begin
                chk($sformatf("v%0d_valid%0d", v, k), idx_valid, 1);
                chk($sformatf("v%0d_index%0d", v, k), index, vecs[v].exp_idx[k]);
                chk($sformatf("v%0d_last%0d", v, k), idx_last, (k == int'(vecs[v].len) - 1));
                chk($sformatf("v%0d_fin%0d", v, k), finished_count, 0);
                tick();
            end
            chk($sformatf("v%0d_done_fin", v), finished_count, 1);
            chk($sformatf("v%0d_done_valid", v), idx_valid, 0);
            chk($sformatf("v%0d_done_busy", v), busy, 0);
            tick();
            chk($sformatf("v%0d_idle_fin", v), finished_count, 0);
            chk($sformatf("v%0d_idle_busy", v), busy, 0);
        end

        // 4-bit wrap: 14,15,0,1.
        cfg_base4 = 4'd14; cfg_stride4 = 4'd1; cfg_len4 = 5'd4; cfg_mode = 0; start4 = 1;
        tick();
        start4 = 0; cfg_len4 = 0;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wrap_index%0d", k), index4, (14 + k) % 16);
            chk($sformatf("wrap_last%0d", k), idx_last4, (k == 3));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            if (fin4) pulses++;
            tick();
        end
        chk("wrap_fin_pulses", pulses, 1);

        // Ready stall on the second index.
        cfg_base = 8'd20; cfg_stride = 8'd3; cfg_len = 9'd4; start = 1; idx_ready = 1;
        tick();
        start = 0;
        tick();
        chk("stall_second", index, 23);
        idx_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("stall_hold%0d", k), index, 23);
            chk($sformatf("stall_valid%0d", k), idx_valid, 1);
        end
        idx_ready = 1;
        xfers = 1; cyc = 0;
        while (!finished_count && cyc < 20) begin
            if (idx_valid) xfers++;
            tick(); cyc++;
        end
        chk("stall_timeout", cyc < 20, 1);
        chk("stall_xfers", xfers, 4);
        tick();

        // CONTINUOUS 0,1,2,0,1,2 then abort.
        cfg_base = 0; cfg_stride = 1; cfg_len = 3; cfg_mode = 1; start = 1;
        tick();
        start = 0;
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("cont_valid%0d", k), idx_valid, 1);
            chk($sformatf("cont_index%0d", k), index, k % 3);
            chk($sformatf("cont_last%0d", k), idx_last, (k % 3 == 2));
            chk($sformatf("cont_fin%0d", k), finished_count, (k > 0 && k % 3 == 0));
            if (k < 6) tick();
        end
        abort = 1;
        tick();
        abort = 0;
        chk("cont_abort_valid", idx_valid, 0);
        chk("cont_abort_busy", busy, 0);
        chk("cont_abort_fin", finished_count, 0);
        cfg_mode = 0;

        // Abort together with the final transfer.
        cfg_base = 5; cfg_stride = 1; cfg_len = 4; start = 1;
        tick();
        start = 0;
        tick(); tick(); tick();
        chk("abx_last", idx_last, 1);
        abort = 1; idx_ready = 1;
        tick();
        abort = 0;
        chk("abx_valid", idx_valid, 0);
        chk("abx_fin", finished_count, 0);
        tick();
        chk("abx_fin2", finished_count, 0);

        // start with len 0 is ignored.
        cfg_len = 0; start = 1;
        tick();
        start = 0;
        chk("len0_busy", busy, 0);
        chk("len0_valid", idx_valid, 0);
        tick();
        chk("len0_busy2", busy, 0);

        // Reset mid-run, then immediate restart.
        cfg_base = 40; cfg_stride = 2; cfg_len = 4; start = 1;
        tick();
        start = 0;
        tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("rst_valid", idx_valid, 0);
        chk("rst_index", index, 0);
        chk("rst_last", idx_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fin", finished_count, 0);
        cfg_base = 9; cfg_stride = 4; cfg_len = 2; start = 1;
        tick();
        start = 0;
        chk("rst_re_idx0", index, 9);
        chk("rst_re_valid", idx_valid, 1);
        tick();
        chk("rst_re_idx1", index, 13);
        chk("rst_re_last", idx_last, 1);
        tick();
        chk("rst_re_fin", finished_count, 1);
        tick();

        // Randomized run against the reference model.
        m_active = 0; m_cool = 0; m_fin = 0; m_k = 0;
        m_base = 0; m_stride = 0; m_len = 0; m_mode = 0;
        for (int c = 0; c < 400; c++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            abort      = ($urandom_range(0, 39) == 0);
            start      = ($urandom_range(0, 3) == 0);
            idx_ready  = ($urandom_range(0, 9) < 7);
            cfg_base   = 8'($urandom);
            cfg_stride = 8'($urandom);
            cfg_len    = 9'($urandom_range(0, 5));
            cfg_mode   = 1'($urandom_range(0, 1));
            model_step(rst_n, start, abort, idx_ready, int'(cfg_base), int'(cfg_stride),
                       int'(cfg_len), cfg_mode);
            tick();
            chk("rnd_valid", idx_valid, m_active);
            chk("rnd_busy", busy, m_active);
            chk("rnd_fin", finished_count, m_fin);
            chk("rnd_last", idx_last, m_active && (m_k == m_len - 1));
            if (m_active) chk("rnd_index", index, (m_base + m_k * m_stride) % 256);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
